demux1_2_stage: RTL and testbench

Registered 1-to-2 demultiplexer, the steering counterpart of the 2:1 datapath mux. It takes one producer stream and routes each word to one of two consumer channels, selected by a per-word select bit. Each output has a one-entry holding register with valid/ready handshake, so pipeline stalls on one consumer do not drop data. It is used where a pipeline stage result fans out to two destinations, such as ALU result to writeback versus memory path. It also supports a synchronous pipeline flush and per-channel transfer counters for debug.

---
 rtl/demux1_2_stage.sv | 61 ++++++
 tb/tb_demux1_2_stage.sv | 113 +++++++++++
 2 files changed

// File: rtl/demux1_2_stage.sv
// demux1_2_stage: registered 1-to-2 demultiplexer with a one-word holding register
// per output channel, a synchronous flush and per-channel transfer counters.
module demux1_2_stage #(
    parameter int DATA_BITS = 32,
    parameter int CNT_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sel,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 out0_valid,
    input  logic                 out0_ready,
    output logic [DATA_BITS-1:0] out0_data,
    output logic                 out1_valid,
    input  logic                 out1_ready,
    output logic [DATA_BITS-1:0] out1_data,
    output logic [CNT_BITS-1:0]  cnt0,
    output logic [CNT_BITS-1:0]  cnt1
);
    logic                 r_valid0, r_valid1;
    logic [DATA_BITS-1:0] r_data0, r_data1;
    logic [CNT_BITS-1:0]  r_cnt0, r_cnt1;
    logic                 w_acc0, w_acc1, w_load0, w_load1, w_drain0, w_drain1;

    // A full channel still accepts when its consumer drains in the same cycle
    assign w_acc0   = !r_valid0 || out0_ready;
    assign w_acc1   = !r_valid1 || out1_ready;
    assign in_ready = !flush && (in_sel ? w_acc1 : w_acc0);
    assign w_load0  = in_valid && in_ready && !in_sel;
    assign w_load1  = in_valid && in_ready && in_sel;
    assign w_drain0 = r_valid0 && out0_ready;
    assign w_drain1 = r_valid1 && out1_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid0 <= 1'b0;
            r_valid1 <= 1'b0;
            r_data0  <= '0;
            r_data1  <= '0;
            r_cnt0   <= '0;
            r_cnt1   <= '0;
        end else begin
            r_valid0 <= !flush && (w_load0 || (r_valid0 && !out0_ready));
            r_valid1 <= !flush && (w_load1 || (r_valid1 && !out1_ready));
            r_data0  <= w_load0 ? in_data : r_data0;
            r_data1  <= w_load1 ? in_data : r_data1;
            r_cnt0   <= r_cnt0 + CNT_BITS'(w_drain0);
            r_cnt1   <= r_cnt1 + CNT_BITS'(w_drain1);
        end
    end

    assign out0_valid = r_valid0;
    assign out1_valid = r_valid1;
    assign out0_data  = r_data0;
    assign out1_data  = r_data1;
    assign cnt0       = r_cnt0;
    assign cnt1       = r_cnt1;
endmodule

// File: tb/tb_demux1_2_stage.sv
// tb_demux1_2_stage: directed and random stimulus against a queue-based reference
// of the two output channels, checked with immediate assertions.
module tb_demux1_2_stage;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, in_sel;
    logic [31:0] in_data, out0_data, out1_data;
    logic        out0_valid, out0_ready, out1_valid, out1_ready;
    logic [3:0]  cnt0, cnt1;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int          c0 = 0;
    int          c1 = 0;

    demux1_2_stage #(.DATA_BITS(32), .CNT_BITS(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
        .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
        .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs();
        chk("out0_valid", 64'(out0_valid), 64'(q0.size() != 0));
        chk("out1_valid", 64'(out1_valid), 64'(q1.size() != 0));
        if (q0.size() != 0) chk("out0_data", 64'(out0_data), 64'(q0[0]));
        if (q1.size() != 0) chk("out1_data", 64'(out1_data), 64'(q1[0]));
        chk("cnt0", 64'(cnt0), 64'(c0 % 16));
        chk("cnt1", 64'(cnt1), 64'(c1 % 16));
    endtask

    // One clock cycle: drive, check the combinational ready, advance the model, check outputs
    task automatic cyc(input logic v, input logic s, input logic [31:0] d,
                       input logic r0, input logic r1, input logic fl);
        logic acc;
        in_valid = v; in_sel = s; in_data = d;
        out0_ready = r0; out1_ready = r1; flush = fl;
        #1;
        acc = !fl && (s ? (q1.size() == 0 || r1) : (q0.size() == 0 || r0));
        chk("in_ready", 64'(in_ready), 64'(acc));
        @(posedge clk);
        if (q0.size() != 0 && r0) begin void'(q0.pop_front()); c0++; end
        if (q1.size() != 0 && r1) begin void'(q1.pop_front()); c1++; end
        if (fl) begin q0.delete(); q1.delete(); end
        if (v && acc) begin
            if (s) q1.push_back(d);
            else   q0.push_back(d);
        end
        #1;
        chk_outs();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
        out0_ready = 1'b0; out1_ready = 1'b0;
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out0_data", 64'(out0_data), 64'd0);
        chk("rst_out1_data", 64'(out1_data), 64'd0);
        chk_outs();
        rst = 1'b0;
        @(negedge clk);
        // first word to channel 0
        cyc(1, 0, 32'hA5A5A5A5, 0, 0, 0);
        cyc(0, 0, 32'h0, 1, 0, 0);
        // back-pressure on channel 1, channel 0 still open
        cyc(1, 1, 32'h11, 0, 0, 0);
        cyc(1, 1, 32'h22, 0, 0, 0);
        chk("bp_hold", 64'(out1_data), 64'h11);
        cyc(1, 0, 32'h33, 0, 0, 0);
        // streaming into channel 0 with ready held high
        for (int i = 0; i < 8; i++) cyc(1, 0, 32'(i), 1, 0, 0);
        cyc(0, 0, 32'h0, 1, 0, 0);
        // flush with both channels full
        cyc(1, 0, 32'h44, 0, 0, 0);
        cyc(1, 1, 32'h55, 0, 0, 1);
        chk("flush_v0", 64'(out0_valid), 64'd0);
        chk("flush_v1", 64'(out1_valid), 64'd0);
        // asynchronous reset between edges with channel 0 full
        cyc(1, 0, 32'h66, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_v0", 64'(out0_valid), 64'd0);
        chk("arst_cnt0", 64'(cnt0), 64'd0);
        chk("arst_cnt1", 64'(cnt1), 64'd0);
        q0.delete(); q1.delete(); c0 = 0; c1 = 0;
        @(negedge clk);
        rst = 1'b0;
        // 17 channel 1 transfers wrap a 4-bit counter to 1
        for (int i = 0; i < 17; i++) cyc(1, 1, 32'(i + 100), 0, 1, 0);
        cyc(0, 1, 32'h0, 0, 1, 0);
        chk("wrap_cnt1", 64'(cnt1), 64'd1);
        chk("wrap_cnt0", 64'(cnt0), 64'd0);
        // randomized traffic
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'($urandom),
                $urandom_range(0, 15) == 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
